// File: rtl/apb1_resp_regs.sv
// apb1_resp_regs: APB responder for the APB1 segment, peripheral side of the
// AHB-to-APB bridge. It decodes four word registers, inserts WAIT_CYCLES wait
// states, returns PSLVERR for illegal accesses, and drains a TX FIFO to a
// downstream valid/ready consumer.
//
// Ports
//   i_pclk, i_prst          clock, synchronous active-high reset
//   i_psel .. i_pprot       APB request (i_pprot[1]=1 marks a non-secure access)
//   o_pready/o_pslverr/o_prdata  APB response, non-zero only in the completion cycle
//   o_ctrl                  CTRL register contents
//   o_fifo_data/o_fifo_vld  FIFO head entry and not-empty flag
//   i_fifo_rdy              consumer pops the head when o_fifo_vld & i_fifo_rdy
//   o_irq                   level interrupt: CTRL[0] & FIFO empty
//
// Register map (byte offset)
//   0x00 CTRL     RW, byte strobes; any non-secure access errors
//   0x04 SCRATCH  RW, byte strobes
//   0x08 TXDATA   write pushes (full-word strobe only, not when full); reads 0
//   0x0C STATUS   RO {20'b0, count[11:8], 6'b0, full, empty}
//   0x10+         error, read data 0
//
// FSM states
//   state   | meaning
//   IDLE    | no transfer in progress; waits for a setup phase
//   WAIT    | access phase; wait counter running, then one completion cycle
//   RESP    | cycle after completion; accepts a back-to-back setup phase
module apb1_resp_regs #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              i_pclk,
    input  logic              i_prst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic              i_pwrite,
    input  logic [31:0]       i_pwdata,
    input  logic [3:0]        i_pstrb,
    input  logic [2:0]        i_pprot,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [31:0]       o_prdata,
    output logic [31:0]       o_ctrl,
    output logic [31:0]       o_fifo_data,
    output logic              o_fifo_vld,
    input  logic              i_fifo_rdy,
    output logic              o_irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] SEL_CTRL    = 2'd0;
    localparam logic [1:0] SEL_SCRATCH = 2'd1;
    localparam logic [1:0] SEL_TX      = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pready_q, pready_d;
    logic       load_req;

    logic [1:0] sel_q;
    logic       wr_q;
    logic       derr_q;

    logic [31:0] ctrl_q;
    logic [31:0] scratch_q;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic fifo_full, fifo_empty;
    logic tx_wr;
    logic pslverr;
    logic commit;
    logic push, pop;

    logic       dec_bad;
    logic [1:0] dec_sel;
    logic       dec_err;

    logic [3:0]  count4;
    logic [31:0] status_word;
    logic [31:0] rdata;

    logic unused_ok;
    assign unused_ok = ^{i_paddr[1:0], i_pprot[2], i_pprot[0]};

    // Address decode and static error checks, latched at the setup phase.
    assign dec_bad = |i_paddr[ADDR_W-1:4];
    assign dec_sel = i_paddr[3:2];
    assign dec_err = dec_bad
                   | ((dec_sel == SEL_CTRL)   & i_pprot[1])
                   | ((dec_sel == SEL_TX)     & i_pwrite & (i_pstrb != 4'hF))
                   | ((dec_sel == SEL_STATUS) & i_pwrite);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign tx_wr      = wr_q & (sel_q == SEL_TX);

    // The FIFO-full error is judged on the count present during the
    // completion cycle, so it is combined here rather than latched at setup.
    assign pslverr = pready_q & (derr_q | (tx_wr & fifo_full));
    assign commit  = i_psel & i_penable & pready_q & ~pslverr;
    assign push    = commit & tx_wr;
    assign pop     = ~fifo_empty & i_fifo_rdy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pready_d = 1'b0;
        load_req = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (i_psel & ~i_penable) begin
                    state_d  = ST_WAIT;
                    load_req = 1'b1;
                    cnt_d    = 4'(WAIT_CYCLES);
                    pready_d = (WAIT_CYCLES == 0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_psel & i_penable) begin
                    if (pready_q) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        pready_d = (cnt_q == 4'd1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            sel_q    <= '0;
            wr_q     <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            if (load_req) begin
                sel_q  <= dec_sel;
                wr_q   <= i_pwrite;
                derr_q <= dec_err;
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
        end else if (commit & wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (i_pstrb[b]) begin
                    if (sel_q == SEL_CTRL)    ctrl_q[8*b +: 8]    <= i_pwdata[8*b +: 8];
                    if (sel_q == SEL_SCRATCH) scratch_q[8*b +: 8] <= i_pwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= i_pwdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count4      = 4'(count_q);
    assign status_word = {20'b0, count4, 6'b0, fifo_full, fifo_empty};

    always_comb begin
        rdata = '0;
        if (pready_q & ~wr_q & ~pslverr) begin
            case (sel_q)
                SEL_CTRL:    rdata = ctrl_q;
                SEL_SCRATCH: rdata = scratch_q;
                SEL_STATUS:  rdata = status_word;
                default:     rdata = '0;
            endcase
        end
    end

    assign o_pready    = pready_q;
    assign o_pslverr   = pslverr;
    assign o_prdata    = rdata;
    assign o_ctrl      = ctrl_q;
    assign o_fifo_vld  = ~fifo_empty;
    assign o_fifo_data = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign o_irq       = ctrl_q[0] & fifo_empty;

endmodule

// File: tb/tb_apb1_resp_regs.sv
module tb_apb1_resp_regs;

    localparam int WAITC = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready, pslverr;
    logic [31:0]   prdata, ctrl, fifo_data;
    logic          fifo_vld, fifo_rdy, irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_ctrl, m_scratch;
    logic [31:0] m_q[$];
    bit          rdy_on_done = 0;

    always #5 clk = ~clk;

    apb1_resp_regs #(.ADDR_W(AW), .WAIT_CYCLES(WAITC), .FIFO_DEPTH(DEPTH)) dut (
        .i_pclk(clk), .i_prst(rst), .i_psel(psel), .i_penable(penable),
        .i_paddr(paddr), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
        .i_pprot(pprot), .o_pready(pready), .o_pslverr(pslverr), .o_prdata(prdata),
        .o_ctrl(ctrl), .o_fifo_data(fifo_data), .o_fifo_vld(fifo_vld),
        .i_fifo_rdy(fifo_rdy), .o_irq(irq)
    );

    // One APB transfer. lat = access cycle in which pready rose, or -1 on
    // timeout / response outputs not zero before completion.
    // Returns at the falling edge of the completion cycle.
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rd, output logic err, output int lat);
        int  n;
        bit  done, dirty;
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1; n = 0; done = 0; dirty = 0; rd = '0; err = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (pready) begin
                done = 1; rd = prdata; err = pslverr;
                if (rdy_on_done) fifo_rdy = 1;
            end else begin
                if (pslverr !== 1'b0 || prdata !== 32'd0) dirty = 1;
                @(posedge clk); #1;
            end
        end
        lat = (done && !dirty) ? n : -1;
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    function automatic logic [31:0] m_status();
        logic [3:0] c;
        c = 4'(m_q.size());
        return {20'b0, c, 6'b0, (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; psel = 0; penable = 0; fifo_rdy = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        m_ctrl = 0; m_scratch = 0; m_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int lat;
        do_reset();
        @(negedge clk);
        n_tests++; if ({pready, pslverr} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b exp 00", {pready, pslverr}); end
        n_tests++; if (prdata !== 32'd0) begin n_fail++; $display("FAIL reset_prdata: got %h exp 0", prdata); end
        n_tests++; if (ctrl !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 0", ctrl); end
        n_tests++; if ({fifo_vld, irq} !== 2'b00 || fifo_data !== 32'd0) begin n_fail++; $display("FAIL reset_fifo: vld %b irq %b data %h exp 0", fifo_vld, irq, fifo_data); end
        apb_xfer(12'h004, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_scratch: got %h err %b exp 0", rd, err); end
        apb_idle();
    endtask

    task automatic test_ctrl_rw();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h000, 1, 32'hA5A5_1234, 4'hF, 3'b000, rd, err, lat);
        n_tests++; if (lat !== WAITC + 1) begin n_fail++; $display("FAIL ctrl_latency: got %0d exp %0d", lat, WAITC + 1); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ctrl_wr_err: got %b exp 0", err); end
        apb_idle();
        @(negedge clk);
        n_tests++; if (ctrl !== 32'hA5A5_1234) begin n_fail++; $display("FAIL ctrl_out: got %h exp a5a51234", ctrl); end
        apb_xfer(12'h000, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'hA5A5_1234 || err !== 1'b0) begin n_fail++; $display("FAIL ctrl_read: got %h err %b exp a5a51234", rd, err); end
        apb_idle();
    endtask

    task automatic test_scratch_strobe();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h004, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, err, lat);
        apb_xfer(12'h004, 1, 32'h0000_00CC, 4'b0001, 3'b000, rd, err, lat);
        apb_xfer(12'h004, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'hFFFF_FFCC) begin n_fail++; $display("FAIL scratch_strobe: got %h exp ffffffcc", rd); end
        apb_xfer(12'h000, 1, 32'h0, 4'hF, 3'b010, rd, err, lat);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL nonsec_wr_err: got %b exp 1", err); end
        apb_xfer(12'h000, 0, 0, 4'h0, 3'b010, rd, err, lat);
        n_tests++; if (err !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL nonsec_rd: got %h err %b exp 0 err 1", rd, err); end
        apb_idle();
        @(negedge clk);
        n_tests++; if (ctrl !== 32'hA5A5_1234) begin n_fail++; $display("FAIL nonsec_ctrl_kept: got %h exp a5a51234", ctrl); end
    endtask

    task automatic test_fifo_fill();
        logic [31:0] rd; logic err; int lat; int errs;
        logic [31:0] held;
        fifo_rdy = 0; errs = 0;
        for (int i = 1; i <= 4; i++) begin
            apb_xfer(12'h008, 1, 32'(i), 4'hF, 3'b000, rd, err, lat);
            if (err !== 1'b0) errs++;
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL fifo_push_err: got %0d errors exp 0", errs); end
        apb_xfer(12'h00C, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'h0000_0402) begin n_fail++; $display("FAIL fifo_full_status: got %h exp 00000402", rd); end
        apb_xfer(12'h008, 1, 32'd5, 4'hF, 3'b000, rd, err, lat);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL fifo_overflow_err: got %b exp 1", err); end
        apb_xfer(12'h00C, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'h0000_0402) begin n_fail++; $display("FAIL fifo_overflow_status: got %h exp 00000402", rd); end
        apb_idle();
        @(negedge clk); held = fifo_data;
        @(negedge clk);
        n_tests++; if (fifo_data !== held || held !== 32'd1) begin n_fail++; $display("FAIL fifo_head_stable: got %h exp 1", fifo_data); end
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (fifo_vld !== 1'b1 || fifo_data !== 32'(i)) begin n_fail++; $display("FAIL fifo_order: got vld %b data %h exp %h", fifo_vld, fifo_data, i); end
            fifo_rdy = 1;
            @(negedge clk);
        end
        fifo_rdy = 0;
        n_tests++; if (fifo_vld !== 1'b0) begin n_fail++; $display("FAIL fifo_drained: got vld %b exp 0", fifo_vld); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h014, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (err !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL unmapped: got %h err %b exp 0 err 1", rd, err); end
        apb_xfer(12'h00C, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, rd, err, lat);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL status_wr: got %b exp 1", err); end
        apb_xfer(12'h008, 1, 32'h1234, 4'h3, 3'b000, rd, err, lat);
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tx_partial: got %b exp 1", err); end
        apb_xfer(12'h008, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (err !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL tx_read: got %h err %b exp 0 err 0", rd, err); end
        apb_xfer(12'h00C, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL tx_partial_nopush: got %h exp 00000001", rd); end
        apb_idle();
    endtask

    task automatic test_push_pop();
        logic [31:0] rd; logic err; int lat;
        apb_xfer(12'h008, 1, 32'hA, 4'hF, 3'b000, rd, err, lat);
        apb_xfer(12'h008, 1, 32'hB, 4'hF, 3'b000, rd, err, lat);
        rdy_on_done = 1;
        apb_xfer(12'h008, 1, 32'hC, 4'hF, 3'b000, rd, err, lat);
        apb_idle();
        fifo_rdy = 0; rdy_on_done = 0;
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL pushpop_err: got %b exp 0", err); end
        apb_xfer(12'h00C, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'h0000_0200) begin n_fail++; $display("FAIL pushpop_count: got %h exp 00000200", rd); end
        apb_xfer(12'h000, 1, 32'h1, 4'hF, 3'b000, rd, err, lat);
        apb_idle();
        @(negedge clk);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_nonempty: got %b exp 0", irq); end
        for (int i = 0; i < 2; i++) begin
            n_tests++; if (fifo_data !== (i == 0 ? 32'hB : 32'hC)) begin n_fail++; $display("FAIL pushpop_order: got %h idx %0d", fifo_data, i); end
            fifo_rdy = 1;
            @(negedge clk);
        end
        fifo_rdy = 0;
        n_tests++; if (irq !== 1'b1 || fifo_vld !== 1'b0) begin n_fail++; $display("FAIL irq_empty: got irq %b vld %b exp 1 0", irq, fifo_vld); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat1, lat2, lat3;
        apb_xfer(12'h004, 1, 32'h1111_2222, 4'hF, 3'b000, rd, err, lat1);
        apb_xfer(12'h004, 1, 32'h0033_0000, 4'b0100, 3'b000, rd, err, lat2);
        apb_xfer(12'h004, 0, 0, 4'h0, 3'b000, rd, err, lat3);
        n_tests++; if (rd !== 32'h1133_2222) begin n_fail++; $display("FAIL b2b_data: got %h exp 11332222", rd); end
        n_tests++; if (lat2 !== WAITC + 1 || lat3 !== WAITC + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d %0d exp %0d", lat2, lat3, WAITC + 1); end
        apb_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat; bit seen;
        seen = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = 12'h004; pwrite = 1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 0;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); if (pready) seen = 1;
        @(posedge clk); #1 psel = 0; penable = 0;
        repeat (3) begin @(negedge clk); if (pready) seen = 1; end
        n_tests++; if (seen) begin n_fail++; $display("FAIL abort_pready: got 1 exp 0"); end
        apb_xfer(12'h004, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'h1133_2222 || lat !== WAITC + 1) begin n_fail++; $display("FAIL abort_noeffect: got %h lat %0d exp 11332222", rd, lat); end
        apb_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat; bit seen;
        seen = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; paddr = 12'h000; pwrite = 1; pwdata = 32'h0F0F_0F0F; pstrb = 4'hF; pprot = 0;
        @(posedge clk); #1 penable = 1;
        @(negedge clk); if (pready) seen = 1;
        rst = 1;
        repeat (3) begin @(negedge clk); if (pready) seen = 1; end
        rst = 0; psel = 0; penable = 0;
        m_ctrl = 0; m_scratch = 0; m_q.delete();
        @(negedge clk); if (pready) seen = 1;
        n_tests++; if (seen) begin n_fail++; $display("FAIL rstmid_pready: got 1 exp 0"); end
        n_tests++; if (ctrl !== 32'd0 || irq !== 1'b0 || fifo_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: ctrl %h irq %b vld %b exp 0", ctrl, irq, fifo_vld); end
        apb_xfer(12'h004, 0, 0, 4'h0, 3'b000, rd, err, lat);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rstmid_scratch: got %h exp 0", rd); end
        apb_xfer(12'h000, 1, 32'h0000_0080, 4'hF, 3'b000, rd, err, lat);
        apb_idle();
        @(negedge clk);
        n_tests++; if (ctrl !== 32'h80 || lat !== WAITC + 1 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_next: ctrl %h lat %0d err %b exp 80", ctrl, lat, err); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, wd; logic err, exp_err, wr; int lat;
        logic [AW-1:0] addr; logic [3:0] strb; logic [2:0] prot;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: addr = 12'h000;
                1: addr = 12'h004;
                2: addr = 12'h008;
                3: addr = 12'h00C;
                default: addr = AW'($urandom_range(16, 4095));
            endcase
            addr[1:0] = 2'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            prot = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'($urandom_range(0, 7)) & 3'b101;
            exp_err = 0; exp_rd = 0;
            if (addr >= 16) exp_err = 1;
            else if (addr[3:2] == 2'd0) begin
                if (prot[1]) exp_err = 1;
                else if (wr) begin for (int b = 0; b < 4; b++) if (strb[b]) m_ctrl[8*b +: 8] = wd[8*b +: 8]; end
                else exp_rd = m_ctrl;
            end else if (addr[3:2] == 2'd1) begin
                if (wr) begin for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = wd[8*b +: 8]; end
                else exp_rd = m_scratch;
            end else if (addr[3:2] == 2'd2) begin
                if (wr) begin
                    if (strb != 4'hF || m_q.size() == DEPTH) exp_err = 1;
                    else m_q.push_back(wd);
                end
            end else begin
                if (wr) exp_err = 1;
                else exp_rd = m_status();
            end
            apb_xfer(addr, wr, wd, strb, prot, rd, err, lat);
            n_tests++;
            if (rd !== exp_rd || err !== exp_err || lat !== WAITC + 1) begin
                n_fail++;
                $display("FAIL rand_xfer %0d: addr %h wr %b got %h err %b lat %0d exp %h err %b", it, addr, wr, rd, err, lat, exp_rd, exp_err);
            end
            if ($urandom_range(0, 3) == 0) begin
                apb_idle();
                @(negedge clk);
                n_tests++;
                if (ctrl !== m_ctrl || irq !== (m_ctrl[0] && m_q.size() == 0) || fifo_vld !== (m_q.size() > 0)) begin
                    n_fail++;
                    $display("FAIL rand_state: ctrl %h irq %b vld %b exp %h", ctrl, irq, fifo_vld, m_ctrl);
                end
                repeat ($urandom_range(0, 5)) begin
                    n_tests++;
                    if (fifo_vld !== (m_q.size() > 0) || (m_q.size() > 0 && fifo_data !== m_q[0])) begin
                        n_fail++;
                        $display("FAIL rand_drain: vld %b data %h exp size %0d", fifo_vld, fifo_data, m_q.size());
                    end
                    fifo_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    if (fifo_rdy && m_q.size() > 0) void'(m_q.pop_front());
                    @(negedge clk);
                end
                fifo_rdy = 0;
            end
        end
        apb_idle();
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        pstrb = '0; pprot = '0; fifo_rdy = 0;
        test_reset();
        test_ctrl_rw();
        test_scratch_strobe();
        test_fifo_fill();
        test_errors();
        test_push_pop();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
